// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Transmit side of the oversampled UART link. Accepts parallel
//            bytes over a valid/ready handshake and serialises them as
//            start / data (LSB first) / [parity] / stop frames on tx. Bit
//            timing comes from the shared baud_en oversample strobe.
// Ports    : clk       - system clock, rising-edge
//            rst_n     - asynchronous active-low reset
//            baud_en   - single-cycle oversample strobe, OVERSAMPLE per bit
//            tx_data   - payload, sampled only in the accept cycle
//            tx_valid  - producer has a byte to send
//            tx_ready  - block can accept a byte (registered)
//            tx        - serial line, idle level 1 (registered)
//            tx_busy   - frame in progress, always ~tx_ready
// Options  : define UART_TX_PARITY_EN to append an even-parity bit after
//            the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int COUNTER_BITS = $clog2(OVERSAMPLE);
  localparam int IDX_BITS     = $clog2(DATA_BITS);

  localparam logic [COUNTER_BITS-1:0] TICK_LAST = COUNTER_BITS'(OVERSAMPLE - 1);
  localparam logic [IDX_BITS-1:0]     IDX_LAST  = IDX_BITS'(DATA_BITS - 1);
  localparam logic                    STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [COUNTER_BITS-1:0] tick_q, tick_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic                    stop_q, stop_d;
  logic                    tx_q, tx_d;
  logic                    ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  // Last oversample pulse of the current bit period.
  logic bit_end;
  assign bit_end = baud_en && (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The tick counter only runs inside a frame; the accept edge forces it
    // to zero so a coincident baud_en is not counted.
    if ((state_q != S_IDLE) && baud_en) begin
      tick_d = bit_end ? '0 : tick_q + COUNTER_BITS'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d  = S_START;
          tick_d   = '0;
          shift_d  = tx_data;
          idx_d    = '0;
          stop_d   = 1'b0;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
            // tx is registered, so drive the bit that becomes bit 0 after
            // this shift.
            tx_d  = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = ~ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Self-checking bench for uart_tx_serializer. A frame-level model
//            (list of expected line levels, pulses counted per bit) predicts
//            tx / tx_ready / tx_busy after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + SB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          baud_en = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx, tx_ready, tx_busy;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .STOP_BITS  (SB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_en  (baud_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   gap_lo = -1000;

  // Reference model: frame as a list of line levels, position = (bit, pulse).
  bit   m_ready = 1'b1;
  int   m_k = 0;
  int   m_p = 0;
  logic m_bits [NB];

  function automatic void load_frame(logic [DB-1:0] d);
    m_bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) m_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
    m_bits[1 + DB] = ^d;
`endif
    for (int s = 0; s < SB; s++) m_bits[1 + DB + PB + s] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // mode 0: baud_en every clk, 1: every 4th clk, 2: random,
  // 3: every 4th clk with a 50-clk blackout starting at gap_lo.
  function automatic bit gen_ben(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4) == 0;
      2:       return $urandom_range(0, 2) != 0;
      default: return ((cyc % 4) == 0) && !((cyc >= gap_lo) && (cyc < gap_lo + 50));
    endcase
  endfunction

  task automatic step(input bit ben, input bit val, input logic [DB-1:0] d);
    logic exp_tx;
    baud_en  = ben;
    tx_valid = val;
    tx_data  = d;
    @(posedge clk);
    cyc++;
    if (m_ready && val) begin
      load_frame(d);
      m_ready = 1'b0;
      m_k = 0;
      m_p = 0;
    end else if (!m_ready && ben) begin
      m_p++;
      if (m_p == OS) begin
        m_p = 0;
        m_k++;
        if (m_k == NB) m_ready = 1'b1;
      end
    end
    #1;
    exp_tx = m_ready ? 1'b1 : m_bits[m_k];
    chk("tx", tx, exp_tx);
    chk("tx_ready", tx_ready, m_ready);
    chk("tx_busy", tx_busy, !m_ready);
  endtask

  // busy_val 0: tx_valid low during frame, 1: held high, 2: random pulses.
  task automatic frame(input logic [DB-1:0] d, input int mode, input int busy_val,
                       input logic [DB-1:0] busy_d, output int busy_cycles);
    int guard;
    bit v;
    guard = 0;
    busy_cycles = 0;
    while (m_ready && guard < 100) begin
      step(gen_ben(mode), 1'b1, d);
      guard++;
    end
    if (m_ready) chk_int("accept_timeout", guard, -1);
    if (!tx_ready) busy_cycles++;
    guard = 0;
    while (!m_ready && guard < 20000) begin
      v = (busy_val == 1) || ((busy_val == 2) && ($urandom_range(0, 3) == 0));
      step(gen_ben(mode), v, (busy_val == 0) ? DB'($urandom) : busy_d);
      if (!tx_ready) busy_cycles++;
      guard++;
    end
    if (!m_ready) chk_int("frame_timeout", guard, -1);
  endtask

  initial begin
    int bc;
    int guard;
    logic [DB-1:0] rd;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    #1 rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b0, '0);

    // 0xA5 at full baud rate; busy for exactly one frame length
    frame(8'hA5, 0, 0, '0, bc);
    chk_int("busy_len_A5", bc, NB * OS);
    repeat (2) step(1'b1, 1'b0, '0);

    // Back-to-back: valid held high, 0x00 then 0xFF
    frame(8'h00, 0, 1, 8'hFF, bc);
    frame(8'hFF, 0, 0, '0, bc);
    chk_int("busy_len_FF", bc, NB * OS);
    repeat (2) step(1'b1, 1'b0, '0);

    // 0x81 pulsed while busy with 0x3C must be ignored
    frame(8'h3C, 0, 2, 8'h81, bc);
    chk_int("busy_len_3C", bc, NB * OS);
    repeat (3) step(1'b1, 1'b0, 8'h81);

    // Asynchronous reset during data bit 3 of 0x55
    guard = 0;
    step(1'b1, 1'b1, 8'h55);
    while (!(m_k == 4 && m_p == 5) && guard < 200) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    chk("mid_frame_busy", tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_ready", tx_ready, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    m_ready = 1'b1;
    m_k = 0;
    m_p = 0;
    @(posedge clk);
    cyc++;
    #1;
    chk("held_rst_tx", tx, 1'b1);
    #3 rst_n = 1'b1;
    frame(8'h55, 0, 0, '0, bc);
    chk_int("busy_len_55", bc, NB * OS);

    // Slow strobe with a 50-clk blackout mid-bit
    gap_lo = cyc + 70;
    frame(8'h5A, 3, 0, '0, bc);
    frame(8'hC3, 1, 0, '0, bc);

    // Parity example byte (parity bit present only when enabled)
    frame(8'h07, 0, 0, '0, bc);
    chk_int("busy_len_07", bc, NB * OS);

    // Randomised frames
    for (int n = 0; n < 8; n++) begin
      rd = DB'($urandom);
      frame(rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)) == 0 ? 2 : 0,
            DB'($urandom), bc);
      repeat ($urandom_range(0, 3)) step(gen_ben(2), 1'b0, '0);
    end
    repeat (4) step(1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
